// File: rtl/pc_fetch_pkg.sv
// Shared state type and constants for the fetch-stage PC sequencer.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        WAIT,
        FLUSH
    } fetch_state_e;

    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] PC_STEP    = 32'd4;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect decode for the EX instruction: taken flag, raw jump/branch target
// and its half-word misalignment. Purely combinational.
module pc_target_calc
    import pc_fetch_pkg::*;
(
    input  logic        jump_i,
    input  logic        jalr_i,
    input  logic        branch_i,
    input  logic        bne_i,
    input  logic        zero_i,
    input  logic [31:0] pc_ex_i,
    input  logic [31:0] imm_ex_i,
    input  logic [31:0] rs1_i,
    output logic        taken_o,
    output logic [31:0] target_o,
    output logic        misaligned_o
);

    logic [31:0] sum_rs1;
    logic [31:0] sum_pc;

    assign sum_rs1 = rs1_i + imm_ex_i;
    assign sum_pc  = pc_ex_i + imm_ex_i;

    // bne only matters when branch is set; a lone bne is not a redirect.
    assign taken_o      = jump_i | (branch_i & (bne_i ? ~zero_i : zero_i));
    assign target_o     = (jump_i & jalr_i) ? {sum_rs1[31:1], 1'b0} : sum_pc;
    assign misaligned_o = target_o[1];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: owns the fetch PC, drives the imem handshake and
// flushes wrong-path work on EX redirects. Optional macro: MISALIGN_TRAP_EN.
//
//  state | meaning
//  BOOT  | one idle cycle after reset release
//  FETCH | request issued unless stalled; advance on grant
//  WAIT  | request outstanding, address frozen until grant
//  FLUSH | bubbles after a redirect, then fetch from target
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic        jalr_i,
    input  logic        branch_i,
    input  logic        bne_i,
    input  logic        zero_i,
    input  logic [31:0] pc_ex_i,
    input  logic [31:0] imm_ex_i,
    input  logic [63:0] rs1_data_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    output logic [31:0] pc_if_o,
    output logic        if_valid_o,
    output logic        flush_o,
    output logic        misalign_trap_o,
    output logic [31:0] bad_target_o
);

    fetch_state_e state_q;
    logic         imem_req_q;
    logic [31:0]  imem_addr_q;
    logic [31:0]  pc_if_q;
    logic         if_valid_q;
    logic         flush_q;
    logic [1:0]   flush_cnt_q;
    logic         pend_q;
    logic [31:0]  pend_tgt_q;

    logic         taken;
    logic [31:0]  target;
    logic         misaligned;
    logic         accept;
    logic [31:0]  redir_tgt;

    pc_target_calc u_target_calc (
        .jump_i       (jump_i),
        .jalr_i       (jalr_i),
        .branch_i     (branch_i),
        .bne_i        (bne_i),
        .zero_i       (zero_i),
        .pc_ex_i      (pc_ex_i),
        .imm_ex_i     (imm_ex_i),
        .rs1_i        (rs1_data_i[31:0]),
        .taken_o      (taken),
        .target_o     (target),
        .misaligned_o (misaligned)
    );

    // A second redirect while one is pending comes from a wrong-path EX op.
    assign accept = taken & ((state_q == FETCH) | ((state_q == WAIT) & ~pend_q));

    logic unused_rs1_hi;
    assign unused_rs1_hi = ^rs1_data_i[63:32];

`ifdef MISALIGN_TRAP_EN
    logic        trap_d;
    logic        trap_q;
    logic [31:0] bad_target_q;

    assign trap_d    = accept & misaligned;
    assign redir_tgt = misaligned ? TRAP_VECTOR : target;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            trap_q       <= 1'b0;
            bad_target_q <= 32'h0;
        end else begin
            trap_q <= trap_d;
            if (trap_d) begin
                bad_target_q <= target;
            end
        end
    end

    assign misalign_trap_o = trap_q;
    assign bad_target_o    = bad_target_q;
`else
    logic unused_trap;
    assign unused_trap     = ^{target[1:0], misaligned, TRAP_VECTOR};
    assign redir_tgt       = {target[31:2], 2'b00};
    assign misalign_trap_o = 1'b0;
    assign bad_target_o    = 32'h0;
`endif

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q     <= BOOT;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_VECTOR;
            pc_if_q     <= 32'h0;
            if_valid_q  <= 1'b0;
            flush_q     <= 1'b0;
            flush_cnt_q <= 2'd0;
            pend_q      <= 1'b0;
            pend_tgt_q  <= 32'h0;
        end else begin
            if_valid_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    state_q     <= FETCH;
                    imem_req_q  <= ~stall_i;
                    imem_addr_q <= RESET_VECTOR;
                end
                FETCH: begin
                    if (imem_req_q && !imem_gnt_i) begin
                        state_q <= WAIT;
                        if (accept) begin
                            pend_q     <= 1'b1;
                            pend_tgt_q <= redir_tgt;
                        end
                    end else if (accept) begin
                        // Any instruction granted this cycle is wrong-path.
                        state_q     <= FLUSH;
                        imem_req_q  <= 1'b0;
                        imem_addr_q <= redir_tgt;
                        flush_q     <= 1'b1;
                        flush_cnt_q <= 2'(FLUSH_CYCLES - 1);
                    end else begin
                        if (imem_req_q) begin
                            if_valid_q  <= 1'b1;
                            pc_if_q     <= imem_addr_q;
                            imem_addr_q <= imem_addr_q + PC_STEP;
                        end
                        imem_req_q <= ~stall_i;
                    end
                end
                WAIT: begin
                    if (imem_gnt_i) begin
                        if (pend_q || accept) begin
                            state_q     <= FLUSH;
                            imem_req_q  <= 1'b0;
                            imem_addr_q <= pend_q ? pend_tgt_q : redir_tgt;
                            flush_q     <= 1'b1;
                            flush_cnt_q <= 2'(FLUSH_CYCLES - 1);
                            pend_q      <= 1'b0;
                        end else begin
                            state_q     <= FETCH;
                            if_valid_q  <= 1'b1;
                            pc_if_q     <= imem_addr_q;
                            imem_addr_q <= imem_addr_q + PC_STEP;
                            imem_req_q  <= ~stall_i;
                        end
                    end else if (accept) begin
                        pend_q     <= 1'b1;
                        pend_tgt_q <= redir_tgt;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == 2'd0) begin
                        state_q    <= FETCH;
                        flush_q    <= 1'b0;
                        imem_req_q <= ~stall_i;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 2'd1;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign imem_req_o  = imem_req_q;
    assign imem_addr_o = imem_addr_q;
    assign pc_if_o     = pc_if_q;
    assign if_valid_o  = if_valid_q;
    assign flush_o     = flush_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int          FC = 2;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        stall = 1'b0, jump = 1'b0, jalr = 1'b0, branch = 1'b0;
    logic        bne = 1'b0, zero = 1'b0, gnt = 1'b1;
    logic [31:0] pc_ex = 32'h0, imm_ex = 32'h0;
    logic [63:0] rs1_data = 64'h0;
    logic        req, valid, flush, trap;
    logic [31:0] addr, pc_if, bad;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .FLUSH_CYCLES(FC)) dut (
        .clk_i(clk), .nrst_i(nrst), .stall_i(stall), .jump_i(jump), .jalr_i(jalr),
        .branch_i(branch), .bne_i(bne), .zero_i(zero), .pc_ex_i(pc_ex),
        .imm_ex_i(imm_ex), .rs1_data_i(rs1_data), .imem_req_o(req),
        .imem_addr_o(addr), .imem_gnt_i(gnt), .pc_if_o(pc_if), .if_valid_o(valid),
        .flush_o(flush), .misalign_trap_o(trap), .bad_target_o(bad)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a fetch either advances, waits on grant, or is replaced
    // by a redirect that costs FC bubble cycles.
    logic        m_boot = 1'b1, m_req = 1'b0, m_valid = 1'b0, m_flush = 1'b0, m_trap = 1'b0;
    logic [31:0] m_addr = RV, m_pc_if = 32'h0, m_bad = 32'h0, m_dtgt = 32'h0;
    logic        m_deferred = 1'b0;
    int          m_bubbles = 0;

    always @(posedge clk or negedge nrst) begin : model
        logic        tk, acc;
        logic [31:0] raw, tgt;
        if (!nrst) begin
            m_boot = 1'b1; m_req = 1'b0; m_addr = RV; m_pc_if = 32'h0;
            m_valid = 1'b0; m_flush = 1'b0; m_trap = 1'b0; m_bad = 32'h0;
            m_bubbles = 0; m_deferred = 1'b0; m_dtgt = 32'h0;
        end else begin
            tk  = jump || (branch && (bne ? !zero : zero));
            raw = (jump && jalr) ? ((rs1_data[31:0] + imm_ex) & ~32'd1) : (pc_ex + imm_ex);
`ifdef MISALIGN_TRAP_EN
            tgt = raw[1] ? TV : raw;
`else
            tgt = raw & ~32'd3;
`endif
            m_valid = 1'b0;
            m_trap  = 1'b0;
            if (m_boot) begin
                m_boot = 1'b0;
                m_req  = !stall;
                m_addr = RV;
            end else if (m_bubbles > 0) begin
                m_bubbles--;
                if (m_bubbles == 0) begin
                    m_flush = 1'b0;
                    m_req   = !stall;
                end
            end else begin
                acc = tk && !m_deferred;
`ifdef MISALIGN_TRAP_EN
                if (acc && raw[1]) begin
                    m_trap = 1'b1;
                    m_bad  = raw;
                end
`endif
                if (m_req && !gnt) begin
                    if (acc) begin
                        m_deferred = 1'b1;
                        m_dtgt     = tgt;
                    end
                end else if (m_deferred || acc) begin
                    m_addr     = m_deferred ? m_dtgt : tgt;
                    m_deferred = 1'b0;
                    m_req      = 1'b0;
                    m_flush    = 1'b1;
                    m_bubbles  = FC;
                end else begin
                    if (m_req) begin
                        m_valid = 1'b1;
                        m_pc_if = m_addr;
                        m_addr  = m_addr + 32'd4;
                    end
                    m_req = !stall;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("imem_req", {31'h0, req}, {31'h0, m_req});
        chk("imem_addr", addr, m_addr);
        chk("pc_if", pc_if, m_pc_if);
        chk("if_valid", {31'h0, valid}, {31'h0, m_valid});
        chk("flush", {31'h0, flush}, {31'h0, m_flush});
        chk("misalign_trap", {31'h0, trap}, {31'h0, m_trap});
        chk("bad_target", bad, m_bad);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        jump = 1'b0; jalr = 1'b0; branch = 1'b0; bne = 1'b0; zero = 1'b0;
    endtask

    logic [31:0] jalr_dest;
    logic [6:0]  vec [12];

    initial begin
`ifdef MISALIGN_TRAP_EN
        jalr_dest = TV;
`else
        jalr_dest = 32'h0000_1004;
`endif
        // reset and sequential fetch with grant tied high
        tick(3);
        chk("rst_req", {31'h0, req}, 32'h0);
        chk("rst_addr", addr, RV);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_flush", {31'h0, flush}, 32'h0);
        nrst = 1'b1;
        tick(1); chk("seq0_addr", addr, 32'h0); chk("seq0_req", {31'h0, req}, 32'h1);
        tick(1); chk("seq1_addr", addr, 32'h4); chk("seq1_valid", {31'h0, valid}, 32'h1);
        tick(1); chk("seq2_addr", addr, 32'h8);
        tick(1); chk("seq3_addr", addr, 32'hC);

        // beq taken backwards
        branch = 1'b1; zero = 1'b1; pc_ex = 32'h40; imm_ex = 32'hFFFF_FFF0;
        tick(1); clr();
        chk("beq_flush1", {31'h0, flush}, 32'h1);
        chk("beq_drop", {31'h0, valid}, 32'h0);
        tick(1); chk("beq_flush2", {31'h0, flush}, 32'h1);
        tick(1); chk("beq_req", {31'h0, req}, 32'h1); chk("beq_tgt", addr, 32'h30);
        chk("beq_flush_end", {31'h0, flush}, 32'h0);

        // beq not taken, lone bne not taken, bne taken
        branch = 1'b1; zero = 1'b0;
        tick(1); clr(); chk("beq_nt_flush", {31'h0, flush}, 32'h0); chk("beq_nt_addr", addr, 32'h34);
        bne = 1'b1;
        tick(1); clr(); chk("bne_nobr_addr", addr, 32'h38);
        branch = 1'b1; bne = 1'b1; pc_ex = 32'h38; imm_ex = 32'h8;
        tick(1); clr(); chk("bne_flush", {31'h0, flush}, 32'h1);
        tick(2); chk("bne_tgt", addr, 32'h40);

        // jalr to a half-word aligned target
        jump = 1'b1; jalr = 1'b1; rs1_data = 64'hDEAD_BEEF_0000_1003; imm_ex = 32'h4;
        tick(1); clr();
`ifdef MISALIGN_TRAP_EN
        chk("jalr_trap", {31'h0, trap}, 32'h1);
        chk("jalr_bad", bad, 32'h0000_1006);
`else
        chk("jalr_trap", {31'h0, trap}, 32'h0);
`endif
        tick(1); chk("jalr_trap_pulse", {31'h0, trap}, 32'h0);
        tick(1); chk("jalr_tgt", addr, jalr_dest); chk("jalr_req", {31'h0, req}, 32'h1);

        // grant low three cycles, jal in the second, ignored second redirect
        gnt = 1'b0;
        tick(1); chk("wait_addr0", addr, jalr_dest);
        jump = 1'b1; pc_ex = 32'h200; imm_ex = 32'h80;
        tick(1); chk("wait_addr1", addr, jalr_dest);
        pc_ex = 32'h500; imm_ex = 32'h0;
        tick(1); clr(); chk("wait_addr2", addr, jalr_dest); chk("wait_req", {31'h0, req}, 32'h1);
        gnt = 1'b1;
        tick(1); chk("wait_drop", {31'h0, valid}, 32'h0); chk("wait_flush", {31'h0, flush}, 32'h1);
        tick(2); chk("wait_tgt", addr, 32'h280);

        // stall four cycles, then stall together with a redirect
        stall = 1'b1;
        tick(1); chk("stall_req0", {31'h0, req}, 32'h0); chk("stall_addr0", addr, 32'h284);
        tick(3); chk("stall_req3", {31'h0, req}, 32'h0); chk("stall_addr3", addr, 32'h284);
        stall = 1'b0;
        tick(1); chk("unstall_req", {31'h0, req}, 32'h1);
        stall = 1'b1; jump = 1'b1; pc_ex = 32'h600; imm_ex = 32'h0;
        tick(1); clr(); stall = 1'b0; chk("stall_tk_flush", {31'h0, flush}, 32'h1);
        tick(2); chk("stall_tk_tgt", addr, 32'h600);

        // address wrap
        jump = 1'b1; pc_ex = 32'h0; imm_ex = 32'hFFFF_FFFC;
        tick(1); clr();
        tick(2); chk("wrap_pre", addr, 32'hFFFF_FFFC);
        tick(1); chk("wrap_post", addr, 32'h0); chk("wrap_pc_if", pc_if, 32'hFFFF_FFFC);

        // reset while a request waits for grant
        tick(1); gnt = 1'b0;
        tick(1); chk("rw_addr", addr, 32'h4);
        #2 nrst = 1'b0;
        #1;
        chk("rw_req", {31'h0, req}, 32'h0);
        chk("rw_addr_rst", addr, RV);
        chk("rw_pc_if", pc_if, 32'h0);
        chk("rw_flush", {31'h0, flush}, 32'h0);
        tick(2); gnt = 1'b1; nrst = 1'b1;
        tick(1); chk("restart_addr", addr, RV); chk("restart_req", {31'h0, req}, 32'h1);

        // short directed mix: {gnt, stall, jump, jalr, branch, bne, zero}
        vec = '{7'b1000000, 7'b0000000, 7'b0100000, 7'b1100000, 7'b1000101,
                7'b1000000, 7'b1000000, 7'b1000000, 7'b0010000, 7'b0000110,
                7'b1000000, 7'b1011000};
        for (int i = 0; i < 12; i++) begin
            {gnt, stall, jump, jalr, branch, bne, zero} = vec[i];
            pc_ex = 32'h800 + 32'(i * 16); imm_ex = 32'h10; rs1_data = 64'h0000_0000_0000_0C02;
            tick(1);
        end
        {gnt, stall} = 2'b10; clr();
        tick(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
